line_writeback: RTL and testbench

Cache-line writeback reader for the data store. Accepts a victim-line request (set index, channel), reads the 128-bit line out of the synchronous data memory, and streams it to the memory bus as narrow beats over a valid/ready handshake. It is the read-side counterpart of the data memory write path and sits between the cache controller's eviction logic and the bus interface.

---
 rtl/line_writeback.sv | 188 ++++++++++++++++++
 tb/tb_line_writeback.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_writeback.sv
// -----------------------------------------------------------------------------
// line_writeback
//
// Cache-line writeback reader. Takes a victim-line request (set index, channel),
// reads the whole line out of the synchronous data memory, and streams it to
// the memory bus as BEAT_WIDTH-wide beats over a valid/ready handshake, low
// beat first. The block only reads the data memory; it has no write enable.
//
// Optional feature (compile-time macro):
//   LINE_WRITEBACK_PARITY_EN  adds output bus_parity = even parity (XOR) of
//                             bus_data, registered together with bus_data.
//
// Ports:
//   clk        in   single clock, rising edge
//   rsta       in   asynchronous active-high reset
//   req_valid  in   writeback request present
//   req_ready  out  block idle, request can be taken
//   req_index  in   set index of the victim line
//   req_chan   in   channel (way) of the victim line
//   mem_index  out  read index to data memory (held from accept to IDLE)
//   mem_chan   out  read channel to data memory
//   mem_rdata  in   data memory read data, one cycle after the address
//   bus_valid  out  beat present
//   bus_ready  in   bus accepts beat
//   bus_data   out  current beat
//   bus_beat   out  beat number, 0 first
//   bus_last   out  final beat of the line
//   bus_addr   out  {chan, index} of the line in transfer
//   done       out  one-cycle pulse after the last beat is accepted
//   bus_parity out  (LINE_WRITEBACK_PARITY_EN only) even parity of bus_data
// -----------------------------------------------------------------------------
module line_writeback #(
    parameter int  INDEX_WIDTH = 4,
    parameter int  CHAN_WIDTH  = 3,
    parameter int  DATA_WIDTH  = 128,
    parameter int  BEAT_WIDTH  = 32,
    localparam int NBEATS      = DATA_WIDTH / BEAT_WIDTH,
    localparam int BEAT_CNT_W  = $clog2(NBEATS)
) (
    input  logic                             clk,
    input  logic                             rsta,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [INDEX_WIDTH-1:0]           req_index,
    input  logic [CHAN_WIDTH-1:0]            req_chan,
    output logic [INDEX_WIDTH-1:0]           mem_index,
    output logic [CHAN_WIDTH-1:0]            mem_chan,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             bus_valid,
    input  logic                             bus_ready,
    output logic [BEAT_WIDTH-1:0]            bus_data,
    output logic [BEAT_CNT_W-1:0]            bus_beat,
    output logic                             bus_last,
    output logic [CHAN_WIDTH+INDEX_WIDTH-1:0] bus_addr,
    output logic                             done
`ifdef LINE_WRITEBACK_PARITY_EN
    ,
    output logic                             bus_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WT   = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NBEATS - 1);

    state_t                              state;
    state_t                              state_nxt;
    logic [INDEX_WIDTH-1:0]              index_q;
    logic [CHAN_WIDTH-1:0]               chan_q;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0]   line_buf;
    logic [BEAT_CNT_W-1:0]               beat_q;
    logic [BEAT_CNT_W-1:0]               beat_nxt;
    logic [BEAT_WIDTH-1:0]               data_q;
    logic [BEAT_WIDTH-1:0]               data_nxt;
    logic                                load_data;
    logic                                done_q;
    logic                                handshake;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_valid) state_nxt = RD;
            RD:   state_nxt = WT;
            WT:   state_nxt = SEND;
            SEND: if (handshake && bus_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = (state == IDLE);
        bus_valid = (state == SEND);
        bus_last  = (state == SEND) && (beat_q == LAST_BEAT);
    end

    assign handshake = bus_valid && bus_ready;

    // The beat register is reloaded when the line arrives (beat 0 straight
    // from the memory) and on every non-final handshake (next slice of the
    // buffer). After the final beat it simply holds until the next line.
    assign beat_nxt  = beat_q + 1'b1;
    assign data_nxt  = (state == WT) ? mem_rdata[BEAT_WIDTH-1:0] : line_buf[beat_nxt];
    assign load_data = (state == WT) || (handshake && !bus_last);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the line buffer is a flop bank, not a RAM, so it takes the
    // asynchronous reset; an abandoned line leaves nothing behind.
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            index_q  <= '0;
            chan_q   <= '0;
            line_buf <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= handshake && bus_last;

            // Request fields are sampled only on acceptance and held until
            // the block is idle again, so the memory address stays stable.
            if (state == IDLE && req_valid) begin
                index_q <= req_index;
                chan_q  <= req_chan;
            end

            if (state == WT) begin
                line_buf <= mem_rdata;
                beat_q   <= '0;
            end else if (handshake) begin
                beat_q <= beat_nxt;   // wraps to 0 after the last beat
            end

            if (load_data) begin
                data_q <= data_nxt;
            end
        end
    end

`ifdef LINE_WRITEBACK_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            parity_q <= 1'b0;
        end else if (load_data) begin
            parity_q <= ^data_nxt;
        end
    end

    assign bus_parity = parity_q;
`endif

    assign mem_index = index_q;
    assign mem_chan  = chan_q;
    assign bus_addr  = {chan_q, index_q};
    assign bus_data  = data_q;
    assign bus_beat  = beat_q;
    assign done      = done_q;

endmodule

// File: tb/tb_line_writeback.sv
// -----------------------------------------------------------------------------
// tb_line_writeback
//
// Self-checking bench for line_writeback. A registered-read memory model feeds
// the DUT; every accepted request pushes its expected beats onto a scoreboard
// queue, and every bus handshake pops and compares. Cycle stamps of accepts,
// first beats and done pulses are checked against the stated latencies.
// -----------------------------------------------------------------------------
module tb_line_writeback;

    localparam int IW = 4;
    localparam int CW = 3;
    localparam int DW = 128;
    localparam int BW = 32;
    localparam int NB = DW / BW;

    typedef struct packed {
        logic [BW-1:0]    data;
        logic [1:0]       beat;
        logic             last;
        logic [CW+IW-1:0] addr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rsta;
    logic              req_valid;
    logic              req_ready;
    logic [IW-1:0]     req_index;
    logic [CW-1:0]     req_chan;
    logic [IW-1:0]     mem_index;
    logic [CW-1:0]     mem_chan;
    logic [DW-1:0]     mem_rdata;
    logic              bus_valid;
    logic              bus_ready;
    logic [BW-1:0]     bus_data;
    logic [1:0]        bus_beat;
    logic              bus_last;
    logic [CW+IW-1:0]  bus_addr;
    logic              done;
`ifdef LINE_WRITEBACK_PARITY_EN
    logic              bus_parity;
`endif

    line_writeback dut (
        .clk       (clk),
        .rsta      (rsta),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
        .req_chan  (req_chan),
        .mem_index (mem_index),
        .mem_chan  (mem_chan),
        .mem_rdata (mem_rdata),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_beat  (bus_beat),
        .bus_last  (bus_last),
        .bus_addr  (bus_addr),
        .done      (done)
`ifdef LINE_WRITEBACK_PARITY_EN
        ,
        .bus_parity(bus_parity)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- counters and check task ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model (1-cycle registered read) ----------------
    logic [DW-1:0] mem [0:(1<<(CW+IW))-1];

    initial begin
        for (int i = 0; i < (1 << (CW + IW)); i++) mem[i] = '0;
    end

    always @(posedge clk) mem_rdata <= mem[{mem_chan, mem_index}];

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus_ready driver with per-beat stalls ----------------
    logic [NB-1:0] stall_mask = '0;
    int            stall_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (bus_valid && stall_mask[bus_beat] && stall_cnt < 2) begin
            bus_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus_ready = 1'b1;
            stall_cnt = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    beat_t exp_q[$];
    int    acc_cyc  [0:31];
    int    fb_cyc   [0:31];
    int    done_cyc [0:31];
    int    acc_n  = 0;
    int    fb_n   = 0;
    int    done_n = 0;
    int    hs_n   = 0;
    logic  pend_done     = 1'b0;
    logic  stall_pending = 1'b0;
    logic [41:0] held;
    logic  held_par;
    logic [CW+IW-1:0] exp_addr = '0;

    always @(negedge clk) begin
        beat_t e;
        logic [DW-1:0] line;
        if (rsta) begin
            pend_done     = 1'b0;
            stall_pending = 1'b0;
            exp_addr      = '0;
        end else begin
            check("done", done, pend_done);
            if (done) begin
                check("done_req_ready", req_ready, 1'b1);
                done_cyc[done_n] = cyc;
                done_n++;
            end
            check("mem_addr", {mem_chan, mem_index}, exp_addr);

            if (stall_pending) begin
                check("stall_valid", bus_valid, 1'b1);
                check("stall_hold", {bus_data, bus_beat, bus_last, bus_addr}, held);
`ifdef LINE_WRITEBACK_PARITY_EN
                check("stall_parity", bus_parity, held_par);
`endif
            end
            stall_pending = bus_valid && !bus_ready;
            held          = {bus_data, bus_beat, bus_last, bus_addr};
`ifdef LINE_WRITEBACK_PARITY_EN
            held_par      = bus_parity;
`else
            held_par      = 1'b0;
`endif

            pend_done = 1'b0;
            if (bus_valid && bus_ready) begin
                hs_n++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", bus_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_data", bus_data, e.data);
                    check("bus_beat", bus_beat, e.beat);
                    check("bus_last", bus_last, e.last);
                    check("bus_addr", bus_addr, e.addr);
`ifdef LINE_WRITEBACK_PARITY_EN
                    check("bus_parity", bus_parity, ^e.data);
`endif
                    if (e.beat == 0) begin
                        fb_cyc[fb_n] = cyc;
                        fb_n++;
                    end
                    pend_done = e.last;
                end
            end

            if (req_valid && req_ready) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                line = mem[{req_chan, req_index}];
                for (int b = 0; b < NB; b++) begin
                    e.data = line[b*BW +: BW];
                    e.beat = 2'(b);
                    e.last = (b == NB - 1);
                    e.addr = {req_chan, req_index};
                    exp_q.push_back(e);
                end
                exp_addr = {req_chan, req_index};
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_acc(input int target);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (acc_n >= target) return;
        end
        check("accept_timeout", acc_n, target);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (done_n >= target) return;
        end
        check("done_timeout", done_n, target);
    endtask

    task automatic send_req(input logic [IW-1:0] idx, input logic [CW-1:0] ch, input logic [DW-1:0] d);
        int n0;
        n0 = acc_n;
        mem[{ch, idx}] = d;
        @(posedge clk);
        #1;
        req_index = idx;
        req_chan  = ch;
        req_valid = 1'b1;
        wait_acc(n0 + 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a0, f0, d0, h0, dsave;
        rsta      = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        req_chan  = '0;
        bus_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_bus_last",  bus_last,  1'b0);
        check("rst_bus_beat",  bus_beat,  2'd0);
        check("rst_bus_data",  bus_data,  32'd0);
        check("rst_bus_addr",  bus_addr,  7'd0);
        check("rst_mem_addr",  {mem_chan, mem_index}, 7'd0);
        @(posedge clk);
        #1;
        rsta = 1'b0;

        // Idle holds with no request
        repeat (3) @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_bus_valid", bus_valid, 1'b0);

        // Single writeback, bus_ready held high
        a0 = acc_n; f0 = fb_n; d0 = done_n;
        send_req(4'd5, 3'd3, 128'h44444444_33333333_22222222_11111111);
        wait_done(d0 + 1);
        check("single_first_beat_lat", fb_cyc[f0] - acc_cyc[a0], 3);
        check("single_done_lat",       done_cyc[d0] - acc_cyc[a0], 7);

        // Backpressure: two stall cycles on beats 1 and 3
        stall_mask = 4'b1010;
        a0 = acc_n; f0 = fb_n; d0 = done_n;
        send_req(4'd1, 3'd2, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
        wait_done(d0 + 1);
        check("bp_first_beat_lat", fb_cyc[f0] - acc_cyc[a0], 3);
        check("bp_done_lat",       done_cyc[d0] - acc_cyc[a0], 11);
        stall_mask = '0;

        // Back-to-back: second request held valid during the first transfer
        a0 = acc_n; f0 = fb_n; d0 = done_n;
        mem[{3'd7, 4'hF}] = 128'h0F0F0F0F_A5A5A5A5_12345678_DEADBEEF;
        @(posedge clk);
        #1;
        req_index = 4'd5;
        req_chan  = 3'd3;
        req_valid = 1'b1;
        wait_acc(a0 + 1);
        @(posedge clk);
        #1;
        req_index = 4'hF;
        req_chan  = 3'd7;
        wait_acc(a0 + 2);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done(d0 + 2);
        check("b2b_done1_lat",     done_cyc[d0] - acc_cyc[a0], 7);
        check("b2b_accept_in_done", acc_cyc[a0 + 1], done_cyc[d0]);
        check("b2b_first_beat2",   fb_cyc[f0 + 1] - acc_cyc[a0 + 1], 3);
        check("b2b_done2_lat",     done_cyc[d0 + 1] - acc_cyc[a0 + 1], 7);

        // Reset mid-line after beat 1 has been accepted
        h0 = hs_n;
        send_req(4'd9, 3'd4, 128'h99990003_88880002_77770001_66660000);
        for (int i = 0; i < 50 && hs_n < h0 + 2; i++) begin
            @(negedge clk);
            #1;
        end
        check("midrst_beats_seen", hs_n - h0, 2);
        dsave = done_n;
        @(posedge clk);
        #2;
        rsta = 1'b1;
        #1;
        check("midrst_bus_valid", bus_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_bus_beat",  bus_beat,  2'd0);
        check("midrst_bus_data",  bus_data,  32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rsta = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("midrst_no_done", done_n, dsave);

        // Next request after reset streams from beat 0
        a0 = acc_n; f0 = fb_n; d0 = done_n;
        send_req(4'd2, 3'd1, 128'h00000007_00000003_00000000_00000007);
        wait_done(d0 + 1);
        check("postrst_first_beat_lat", fb_cyc[f0] - acc_cyc[a0], 3);
        check("postrst_done_lat",       done_cyc[d0] - acc_cyc[a0], 7);

`ifdef LINE_WRITEBACK_PARITY_EN
        // Parity: beat 0 = 0x7 (odd bit count), beat 1 = 0x3 (even bit count)
        stall_mask = 4'b0011;
        d0 = done_n;
        send_req(4'd6, 3'd0, 128'h00000001_00000000_00000003_00000007);
        wait_done(d0 + 1);
        stall_mask = '0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
